// File: rtl/mem_port_arb.sv
// mem_port_arb
// Arbitrates one shared single-ported memory between instruction fetch (IF)
// and the data access of the MEM stage. The FSM idles, grants one requester,
// holds the port strobes until the memory reports port_ready, then returns
// to IDLE for one cycle (the done-pulse cycle) before granting again.
// Data normally has fixed priority over fetch.
//
// Optional feature (macro ARB_STARVE_GUARD_EN): a 2-bit starvation counter
// tracks consecutive data grants taken while a fetch was also waiting. Once
// it reaches 3, the next IDLE cycle with both requests pending grants IF.
//
// Ports
//   clk, reset             sole clock; asynchronous active-high reset
//   if_req, if_addr        fetch read request and PC
//   mem_read, mem_write    data request strobes (store wins if both are set)
//   mem_addr, mem_wdata    data address / store data
//   port_addr, port_wdata  shared memory address / write data (combinational)
//   port_re, port_we       shared memory read / write strobes
//   port_rdata, port_ready memory read data and access-complete indication
//   if_rdata, mem_rdata    registered read data per requester
//   if_done, mem_done      one-cycle completion pulses
//   c_PCWrite, c_IFIDWrite 0 = hold PC / hold IF/ID
//   c_memStall             1 = freeze EX/MEM and earlier, bubble into MEM/WB
module mem_port_arb (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] port_addr,
   output logic [31:0] port_wdata,
   output logic        port_re,
   output logic        port_we,
   input  logic [31:0] port_rdata,
   input  logic        port_ready,
   output logic [31:0] if_rdata,
   output logic [31:0] mem_rdata,
   output logic        if_done,
   output logic        mem_done,
   output logic        c_PCWrite,
   output logic        c_IFIDWrite,
   output logic        c_memStall
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SERVE_IF  = 2'd1,
      SERVE_MEM = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   mem_req;
   logic   if_wins;

   assign mem_req = mem_read | mem_write;

`ifdef ARB_STARVE_GUARD_EN
   // Counts data grants taken while fetch was waiting; saturates at 3.
   // A data grant with no fetch pending breaks the streak.
   logic [1:0] starve_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= 2'd0;
      end else if (state == IDLE) begin
         if (state_nxt == SERVE_IF) begin
            starve_cnt <= 2'd0;
         end else if (state_nxt == SERVE_MEM) begin
            if (!if_req)
               starve_cnt <= 2'd0;
            else if (starve_cnt != 2'd3)
               starve_cnt <= starve_cnt + 2'd1;
         end
      end
   end

   assign if_wins = if_req & (~mem_req | (starve_cnt == 2'd3));
`else
   assign if_wins = if_req & ~mem_req;
`endif

   // Next state and port drive. Port outputs follow the granted requester's
   // live inputs, so a requester that drops mid-access still completes with
   // whatever it presents (a dropped store degrades to a read strobe).
   always_comb begin
      state_nxt  = state;
      port_addr  = 32'd0;
      port_wdata = 32'd0;
      port_re    = 1'b0;
      port_we    = 1'b0;
      case (state)
         IDLE: begin
            if (if_wins)
               state_nxt = SERVE_IF;
            else if (mem_req)
               state_nxt = SERVE_MEM;
         end
         SERVE_IF: begin
            port_addr = if_addr;
            port_re   = 1'b1;
            if (port_ready)
               state_nxt = IDLE;
         end
         SERVE_MEM: begin
            port_addr  = mem_addr;
            port_wdata = mem_wdata;
            if (mem_write)
               port_we = 1'b1;
            else
               port_re = 1'b1;
            if (port_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         if_rdata  <= 32'd0;
         mem_rdata <= 32'd0;
         if_done   <= 1'b0;
         mem_done  <= 1'b0;
      end else begin
         state    <= state_nxt;
         // port_ready only counts inside a SERVE state; in IDLE it is ignored.
         if_done  <= (state == SERVE_IF) & port_ready;
         mem_done <= (state == SERVE_MEM) & port_ready;
         if ((state == SERVE_IF) && port_ready)
            if_rdata <= port_rdata;
         // A store leaves the previous load data in place.
         if ((state == SERVE_MEM) && port_ready && !mem_write)
            mem_rdata <= port_rdata;
      end
   end

   // Reset terms make the pipeline controls take their idle values at once,
   // independent of whatever requests are presented during reset.
   assign c_memStall  = ~reset & mem_req & ~mem_done;
   assign c_PCWrite   = reset | ~((if_req & ~if_done) | c_memStall);
   assign c_IFIDWrite = c_PCWrite;

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus randomized
// request traffic checked against a transaction-level reference model.
module tb_mem_port_arb;

`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] port_addr;
   logic [31:0] port_wdata;
   logic        port_re;
   logic        port_we;
   logic [31:0] port_rdata;
   logic        port_ready;
   logic [31:0] if_rdata;
   logic [31:0] mem_rdata;
   logic        if_done;
   logic        mem_done;
   logic        c_PCWrite;
   logic        c_IFIDWrite;
   logic        c_memStall;

   int          total;
   int          bad;
   logic [31:0] m_if;     // model of if_rdata
   logic [31:0] m_mem;    // model of mem_rdata
   int          streak;   // model: consecutive data grants while fetch waited

   mem_port_arb dut (
      .clk        (clk),
      .reset      (reset),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .port_addr  (port_addr),
      .port_wdata (port_wdata),
      .port_re    (port_re),
      .port_we    (port_we),
      .port_rdata (port_rdata),
      .port_ready (port_ready),
      .if_rdata   (if_rdata),
      .mem_rdata  (mem_rdata),
      .if_done    (if_done),
      .mem_done   (mem_done),
      .c_PCWrite  (c_PCWrite),
      .c_IFIDWrite(c_IFIDWrite),
      .c_memStall (c_memStall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "simulation timeout");
   end

   // Leaves the bench at a falling edge with reset just released.
   task automatic do_reset();
      reset = 1'b1;
      if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
      port_ready = 1'b0; port_rdata = 32'd0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_if = 32'd0; m_mem = 32'd0; streak = 0;
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1'b1;
      if_req = 1'b1; mem_read = 1'b1;
      if_addr = 32'h0000_5678; mem_addr = 32'h0000_1234; mem_wdata = 32'hCAFE_F00D;
      #1;
      total++;
      if ({port_re, port_we, if_done, mem_done} !== 4'b0000) begin
         bad++; $display("FAIL reset_strobes got=%b want=0000", {port_re, port_we, if_done, mem_done});
      end
      total++;
      if ({port_addr, port_wdata, if_rdata, mem_rdata} !== 128'd0) begin
         bad++; $display("FAIL reset_data got=%h %h %h %h want=0", port_addr, port_wdata, if_rdata, mem_rdata);
      end
      total++;
      if ({c_memStall, c_PCWrite, c_IFIDWrite} !== 3'b011) begin
         bad++; $display("FAIL reset_ctrl got=%b want=011", {c_memStall, c_PCWrite, c_IFIDWrite});
      end
      @(negedge clk);
      reset = 1'b0;
      if_req = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if ({port_re, port_we, port_addr} !== {2'b10, 32'h0000_1234}) begin
         bad++; $display("FAIL reset_resume got=%b%b %h want=10 00001234", port_re, port_we, port_addr);
      end
      port_ready = 1'b1; port_rdata = 32'h1357_9BDF;
      @(negedge clk);
      port_ready = 1'b0; mem_read = 1'b0;
      #1;
      total++;
      if ({mem_done, mem_rdata} !== {1'b1, 32'h1357_9BDF}) begin
         bad++; $display("FAIL reset_first_done got=%b %h want=1 13579bdf", mem_done, mem_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_fetch();
      logic [31:0] d;
      do_reset();
      if_req = 1'b1; if_addr = 32'h0040_0004;
      #1;
      total++;
      if ({port_re, c_PCWrite, c_IFIDWrite} !== 3'b000) begin
         bad++; $display("FAIL fetch_req_cycle got=%b want=000", {port_re, c_PCWrite, c_IFIDWrite});
      end
      @(negedge clk);
      d = $urandom; port_ready = 1'b1; port_rdata = d;
      #1;
      total++;
      if ({port_re, port_we, port_addr, c_PCWrite, if_done} !== {2'b10, 32'h0040_0004, 2'b00}) begin
         bad++; $display("FAIL fetch_serve got=%b%b %h %b%b want=10 00400004 00", port_re, port_we, port_addr, c_PCWrite, if_done);
      end
      @(negedge clk);
      port_ready = 1'b0;
      #1;
      total++;
      if ({if_done, if_rdata, port_re, c_PCWrite} !== {1'b1, d, 1'b0, 1'b1}) begin
         bad++; $display("FAIL fetch_done got=%b %h %b %b want=1 %h 0 1", if_done, if_rdata, port_re, c_PCWrite, d);
      end
      if_req = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if ({if_done, mem_done} !== 2'b00) begin
         bad++; $display("FAIL fetch_pulse_len got=%b want=00", {if_done, mem_done});
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] d1, d2;
      do_reset();
      d1 = $urandom; d2 = $urandom;
      if_req = 1'b1; if_addr = 32'h0040_0008;
      mem_read = 1'b1; mem_addr = 32'h1001_0000;
      #1;
      total++;
      if ({c_memStall, c_PCWrite} !== 2'b10) begin
         bad++; $display("FAIL sim_ctrl got=%b want=10", {c_memStall, c_PCWrite});
      end
      @(negedge clk);
      port_ready = 1'b1; port_rdata = d1;
      #1;
      total++;
      if ({port_re, port_we, port_addr} !== {2'b10, 32'h1001_0000}) begin
         bad++; $display("FAIL sim_mem_first got=%b%b %h want=10 10010000", port_re, port_we, port_addr);
      end
      @(negedge clk);
      port_ready = 1'b0; mem_read = 1'b0;
      #1;
      total++;
      if ({mem_done, if_done, port_re, port_we, mem_rdata} !== {4'b1000, d1}) begin
         bad++; $display("FAIL sim_idle_gap got=%b%b%b%b %h want=1000 %h", mem_done, if_done, port_re, port_we, mem_rdata, d1);
      end
      @(negedge clk);
      port_ready = 1'b1; port_rdata = d2;
      #1;
      total++;
      if ({port_re, port_addr, mem_done} !== {1'b1, 32'h0040_0008, 1'b0}) begin
         bad++; $display("FAIL sim_if_second got=%b %h %b want=1 00400008 0", port_re, port_addr, mem_done);
      end
      @(negedge clk);
      port_ready = 1'b0;
      #1;
      total++;
      if ({if_done, if_rdata} !== {1'b1, d2}) begin
         bad++; $display("FAIL sim_if_done got=%b %h want=1 %h", if_done, if_rdata, d2);
      end
      if_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store();
      do_reset();
      mem_read = 1'b1; mem_addr = 32'h1001_0004;
      @(negedge clk);
      port_ready = 1'b1; port_rdata = 32'hA5A5_0001;
      @(negedge clk);
      port_ready = 1'b0;
      mem_write = 1'b1; mem_wdata = 32'hDEAD_BEEF; mem_addr = 32'h1001_0008;
      @(negedge clk);
      port_ready = 1'b1; port_rdata = 32'hFFFF_FFFF;
      #1;
      total++;
      if ({port_we, port_re, port_addr, port_wdata} !== {2'b10, 32'h1001_0008, 32'hDEAD_BEEF}) begin
         bad++; $display("FAIL store_strobes got=%b%b %h %h want=10 10010008 deadbeef", port_we, port_re, port_addr, port_wdata);
      end
      @(negedge clk);
      port_ready = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      #1;
      total++;
      if ({mem_done, mem_rdata} !== {1'b1, 32'hA5A5_0001}) begin
         bad++; $display("FAIL store_keeps_rdata got=%b %h want=1 a5a50001", mem_done, mem_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_wait_states();
      int held, pulses;
      do_reset();
      held = 0; pulses = 0;
      mem_read = 1'b1; mem_addr = $urandom;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         port_ready = (k == 5); port_rdata = 32'h0BAD_CAFE;
         #1;
         if (port_re && c_memStall && !mem_done) held++;
      end
      total++;
      if (held !== 6) begin
         bad++; $display("FAIL wait_hold got=%0d want=6", held);
      end
      @(negedge clk);
      port_ready = 1'b0;
      #1;
      total++;
      if ({mem_done, c_memStall, port_re} !== 3'b100) begin
         bad++; $display("FAIL wait_done got=%b want=100", {mem_done, c_memStall, port_re});
      end
      mem_read = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         if (mem_done) pulses++;
      end
      total++;
      if (pulses !== 0) begin
         bad++; $display("FAIL wait_single_pulse got=%0d extra want=0", pulses);
      end
   endtask

   task automatic test_ready_idle_and_drop();
      logic [31:0] d;
      do_reset();
      port_ready = 1'b1; port_rdata = 32'h7777_7777;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         total++;
         if ({if_done, mem_done, if_rdata, mem_rdata} !== 66'd0) begin
            bad++; $display("FAIL idle_ready_ignored got=%b%b %h %h want=00 0 0", if_done, mem_done, if_rdata, mem_rdata);
         end
      end
      port_ready = 1'b0;
      if_req = 1'b1; if_addr = 32'h0040_0010;
      @(negedge clk);
      if_req = 1'b0;
      #1;
      total++;
      if ({port_re, port_addr} !== {1'b1, 32'h0040_0010}) begin
         bad++; $display("FAIL drop_still_served got=%b %h want=1 00400010", port_re, port_addr);
      end
      @(negedge clk);
      d = $urandom; port_ready = 1'b1; port_rdata = d;
      @(negedge clk);
      port_ready = 1'b0;
      #1;
      total++;
      if ({if_done, if_rdata} !== {1'b1, d}) begin
         bad++; $display("FAIL drop_done got=%b %h want=1 %h", if_done, if_rdata, d);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_write = 1'b1; mem_addr = 32'h1001_0020; mem_wdata = 32'h1234_5678;
      @(negedge clk);
      #1;
      total++;
      if ({port_we, port_addr} !== {1'b1, 32'h1001_0020}) begin
         bad++; $display("FAIL rstmid_pre got=%b %h want=1 10010020", port_we, port_addr);
      end
      #1;
      reset = 1'b1;
      port_ready = 1'b1;
      #1;
      total++;
      if ({port_we, port_re, port_addr, port_wdata, c_memStall, c_PCWrite} !== {2'b00, 64'd0, 2'b01}) begin
         bad++; $display("FAIL rstmid_async got=%b%b %h %h %b%b want=00 0 0 01", port_we, port_re, port_addr, port_wdata, c_memStall, c_PCWrite);
      end
      @(negedge clk);
      reset = 1'b0; mem_write = 1'b0; port_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         total++;
         if ({mem_done, port_we, port_re} !== 3'b000) begin
            bad++; $display("FAIL rstmid_no_done got=%b want=000", {mem_done, port_we, port_re});
         end
      end
   endtask

   task automatic test_starve();
      logic if_won;
      do_reset();
      if_req = 1'b1; if_addr = 32'h0040_0100;
      if_won = 1'b0;
      for (int g = 0; g < 4; g++) begin
         mem_read = 1'b1; mem_addr = 32'h1001_0100 + 32'(g);
         @(negedge clk);
         port_ready = 1'b1; port_rdata = $urandom;
         #1;
         if_won = (port_addr == 32'h0040_0100);
         if (g == 3) begin
            total++;
            if (if_won !== GUARD) begin
               bad++; $display("FAIL starve_4th_grant got_if=%b want_if=%b", if_won, GUARD);
            end
         end else begin
            total++;
            if (port_addr !== 32'h1001_0100 + 32'(g)) begin
               bad++; $display("FAIL starve_mem_grant%0d got=%h want=%h", g, port_addr, 32'h1001_0100 + 32'(g));
            end
         end
         @(negedge clk);
         port_ready = 1'b0;
         if (!if_won) mem_read = 1'b0;
      end
      if_req = 1'b0; mem_read = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random(input int n);
      logic ci, cr, cw, mreq, win_if, exp_ifd, exp_memd, st_exp, pc_exp;
      logic [31:0] last_rd;
      int w;
      do_reset();
      ci = 1'b0; cr = 1'b0; cw = 1'b0; exp_ifd = 1'b0; exp_memd = 1'b0; last_rd = 32'd0;
      for (int it = 0; it < n; it++) begin
         if (it != 0) @(negedge clk);
         if (!ci && $urandom_range(0, 1) == 1) begin ci = 1'b1; if_addr = $urandom; end
         if (!cr && !cw && $urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 2))
               0:       cr = 1'b1;
               1:       cw = 1'b1;
               default: begin cr = 1'b1; cw = 1'b1; end
            endcase
            mem_addr = $urandom; mem_wdata = $urandom;
         end
         if (!ci && !cr && !cw) begin ci = 1'b1; if_addr = $urandom; end
         if_req = ci; mem_read = cr; mem_write = cw;
         port_ready = 1'($urandom_range(0, 1)); port_rdata = $urandom;
         mreq = cr | cw;
         st_exp = mreq & ~exp_memd;
         pc_exp = ~((ci & ~exp_ifd) | st_exp);
         #1;
         total++;
         if ({if_done, mem_done, port_re, port_we} !== {exp_ifd, exp_memd, 2'b00}) begin
            bad++; $display("FAIL rnd_idle_flags it=%0d got=%b want=%b", it, {if_done, mem_done, port_re, port_we}, {exp_ifd, exp_memd, 2'b00});
         end
         total++;
         if ({if_rdata, mem_rdata} !== {m_if, m_mem}) begin
            bad++; $display("FAIL rnd_rdata it=%0d got=%h %h want=%h %h", it, if_rdata, mem_rdata, m_if, m_mem);
         end
         total++;
         if ({c_memStall, c_PCWrite, c_IFIDWrite} !== {st_exp, pc_exp, pc_exp}) begin
            bad++; $display("FAIL rnd_ctrl it=%0d got=%b want=%b", it, {c_memStall, c_PCWrite, c_IFIDWrite}, {st_exp, pc_exp, pc_exp});
         end
         // Reference arbitration: data first, unless the starvation guard
         // has seen three data grants in a row taken while fetch waited.
         win_if = ci & (~mreq | (GUARD & (streak == 3)));
         if (win_if) streak = 0;
         else if (ci) streak = (streak < 3) ? streak + 1 : 3;
         else streak = 0;
         w = $urandom_range(0, 3);
         for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            port_ready = (k == w); port_rdata = $urandom; last_rd = port_rdata;
            #1;
            total++;
            if (win_if) begin
               if ({port_re, port_we, port_addr} !== {2'b10, if_addr}) begin
                  bad++; $display("FAIL rnd_if_port it=%0d got=%b%b %h want=10 %h", it, port_re, port_we, port_addr, if_addr);
               end
            end else if ({port_re, port_we, port_addr, port_wdata} !== {~cw, cw, mem_addr, mem_wdata}) begin
               bad++; $display("FAIL rnd_mem_port it=%0d got=%b%b %h %h want=%b%b %h %h", it, port_re, port_we, port_addr, port_wdata, ~cw, cw, mem_addr, mem_wdata);
            end
            total++;
            if ({if_done, mem_done, c_memStall} !== {2'b00, mreq}) begin
               bad++; $display("FAIL rnd_serve_ctrl it=%0d got=%b want=%b", it, {if_done, mem_done, c_memStall}, {2'b00, mreq});
            end
         end
         exp_ifd = win_if; exp_memd = ~win_if;
         if (win_if) begin
            m_if = last_rd; ci = 1'b0;
         end else begin
            if (!cw) m_mem = last_rd;
            cr = 1'b0; cw = 1'b0;
         end
      end
      @(negedge clk);
      if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0; port_ready = 1'b0;
      #1;
      total++;
      if ({if_done, mem_done, if_rdata, mem_rdata} !== {exp_ifd, exp_memd, m_if, m_mem}) begin
         bad++; $display("FAIL rnd_final got=%b%b %h %h want=%b%b %h %h", if_done, mem_done, if_rdata, mem_rdata, exp_ifd, exp_memd, m_if, m_mem);
      end
      @(negedge clk);
   endtask

   initial begin
      total = 0; bad = 0;
      test_reset();
      test_fetch();
      test_simultaneous();
      test_store();
      test_wait_states();
      test_ready_idle_and_drop();
      test_reset_mid();
      test_starve();
      test_random(80);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
